sipo_deserializer: RTL and testbench
====================================

// Module: sipo_deserializer
// PURPOSE
//   Receive end of the nibble shift-register datapath: serial-in, parallel-out.
//   Collects a framed serial bit stream, MSB first, into WIDTH-bit words.
//   Presents each completed word on a valid/ready output register.
//   The serial side cannot be stalled; loss is flagged, never back-pressured.
// PARAMETERS
//   WIDTH   4   data bits per word (>=2)
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous, active-high reset
//   s_in       in   1      serial data bit
//   s_valid    in   1      s_in is sampled on this edge; low = line gap, state held
//   s_start    in   1      qualifies s_valid; marks the first (MSB) bit of a word
//   p_out      out  WIDTH  assembled word; stable while p_valid && !p_ready
//   p_valid    out  1      p_out holds an unconsumed word
//   p_ready    in   1      consumer takes the word when p_valid && p_ready
//   overrun    out  1      1-cycle pulse: completed word dropped, output register full
//   frame_err  out  1      1-cycle pulse: s_start arrived mid-word, partial word discarded
//   par_err    out  1      parity result for p_out, valid with p_valid (see CONFIGURATION)
// BEHAVIOUR
//   Reset: async on rst high. State IDLE; bit counter, shift reg, p_out = 0.
//     p_valid, overrun, frame_err, par_err = 0. Reset mid-word discards the partial word.
//   Shift: on each accepted bit, sr <= {sr[WIDTH-2:0], s_in}; count increments.
//   FSM:
//     IDLE  : s_valid&&s_start -> take bit, count=1, go SHIFT.
//             s_valid&&!s_start -> bit ignored, no flag.
//     SHIFT : s_valid&&!s_start -> take bit. On WIDTH-th bit -> complete, go IDLE
//             (or PARITY if parity is compiled in).
//             s_valid&&s_start -> frame_err pulse; bit taken as MSB of a new word, count=1.
//     PARITY: s_valid -> take parity bit, complete, go IDLE.
//             s_start here -> frame_err pulse, restart as in SHIFT.
//   Complete, same edge as the last bit:
//     if !p_valid || p_ready: p_out <= {sr[WIDTH-2:0], s_in} and p_valid <= 1.
//       Latency: p_valid is high the cycle after the last bit's edge.
//     else: word dropped, p_out unchanged, overrun pulses.
//   Drain: p_valid && p_ready with no load on the same edge -> p_valid <= 0.
//     Load and drain on the same edge -> p_valid stays 1 with the new word.
//   Line gaps: gaps of any length between bits are legal. Counter and sr hold.
//   Back-to-back words with p_ready=1 sustain 1 word per WIDTH accepted bits.
// CONFIGURATION
//   DESER_PARITY_EN defined:
//     One even-parity bit follows every WIDTH data bits.
//     par_err = ^{word, parity bit}, registered with p_out.
//     Overrun and drain rules apply at the parity-bit edge.
//   DESER_PARITY_EN undefined:
//     No PARITY state; a word completes on its WIDTH-th bit.
//     par_err tied to 0.
// STRUCTURE
//   Package deser_pkg holds:
//     FSM state encodings IDLE/SHIFT/PARITY as localparams.
//     Counter width function clog2(WIDTH+1).
//     Even-parity function.
//   One sub-module, deser_out_reg: holding register for p_out/p_valid/par_err.
//     Implements the load/drain/overrun rules.
//   FSM, counter and shift register live in the top module.
// TESTING (WIDTH=4)
//   1. rst pulse mid-word -> p_valid=0, p_out=0, flags 0; next framed word 1,0,1,1 -> p_out=4'b1011.
//   2. Bits 1,0,1,1 with start on the first, p_ready=1 -> p_valid high for one cycle
//      after the 4th bit edge, p_out=4'b1011.
//   3. Same word with s_valid low 3 cycles between bits -> p_out=4'b1011, no flags.
//   4. p_ready=0, words 1011 then 0110 -> p_out stays 1011, overrun pulses at the 2nd
//      word's last bit; then p_ready=1 -> p_valid drops next cycle.
//   5. Start, 1,1, then start with 0,1,1,0 -> frame_err pulse on the 2nd start, p_out=4'b0110.
//   6. DESER_PARITY_EN: 1011 + parity 1 -> par_err=0; 1011 + parity 0 -> par_err=1.

Source files
------------

// File: rtl/deser_pkg.sv
// deser_pkg: shared definitions for the SIPO deserializer.
//   - FSM state encodings (IDLE/SHIFT/PARITY) and the state enum built on them
//   - cnt_w(): bit-counter width needed to count 0..width
//   - even_par(): XOR reduction; 1 means an odd number of ones (even-parity error)
// Optional feature macro used by the design files: DESER_PARITY_EN.
package deser_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE   = IDLE,
    S_SHIFT  = SHIFT,
    S_PARITY = PARITY
  } state_e;

  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

  // Word and parity bit are zero-extended by the caller; zeros do not
  // change the XOR, so one 64-bit version serves every WIDTH.
  function automatic logic even_par(input logic [63:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/deser_out_reg.sv
// deser_out_reg: valid/ready holding register for assembled words.
//   Loads a completed word when empty or being drained on the same edge;
//   otherwise drops it and pulses overrun for one cycle.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   load_i       a word completed on this edge
//   word_i       the completed word
//   par_i        parity result to register alongside the word
//   ready_i      consumer accepts data_o when valid_o is high
//   data_o       held word (stable while valid_o && !ready_i)
//   valid_o      data_o holds an unconsumed word
//   par_err_o    parity result registered with data_o
//   overrun_o    1-cycle pulse: completed word dropped
// Configuration macro DESER_PARITY_EN only affects what drives par_i.
module deser_out_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] word_i,
  input  logic             par_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             par_err_o,
  output logic             overrun_o
);

  logic [WIDTH-1:0] data_q,    data_d;
  logic             valid_q,   valid_d;
  logic             par_q,     par_d;
  logic             overrun_q, overrun_d;

  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    par_d     = par_q;
    overrun_d = 1'b0;
    if (load_i) begin
      // A drain on the same edge frees the slot for the new word.
      if (!valid_q || ready_i) begin
        data_d  = word_i;
        valid_d = 1'b1;
        par_d   = par_i;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      par_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      par_q     <= par_d;
      overrun_q <= overrun_d;
    end
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign par_err_o = par_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/sipo_deserializer.sv
// sipo_deserializer: serial-in, parallel-out receiver for a framed bit stream.
//   Bits arrive MSB first; s_start marks the first bit of each word. The serial
//   side is never stalled: a word that completes while the output register is
//   still full is dropped and flagged with overrun.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   s_in       serial data bit, sampled when s_valid is high
//   s_valid    bit qualifier; low is a line gap (state held)
//   s_start    marks the MSB of a word (qualified by s_valid)
//   p_out      assembled word, p_valid/p_ready handshake
//   p_valid    p_out holds an unconsumed word
//   p_ready    consumer takes the word when p_valid && p_ready
//   overrun    1-cycle pulse: completed word dropped (output full)
//   frame_err  1-cycle pulse: s_start arrived mid-word
//   par_err    parity result registered with p_out
// Configuration: define DESER_PARITY_EN to expect one even-parity bit after
//   every WIDTH data bits; otherwise words complete on the WIDTH-th bit and
//   par_err is 0.
module sipo_deserializer
  import deser_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_in,
  input  logic             s_valid,
  input  logic             s_start,
  output logic [WIDTH-1:0] p_out,
  output logic             p_valid,
  input  logic             p_ready,
  output logic             overrun,
  output logic             frame_err,
  output logic             par_err
);

  localparam int CW = cnt_w(WIDTH);

  // With parity the full word must be held while the parity bit arrives;
  // without it the last data bit goes straight to the output register.
`ifdef DESER_PARITY_EN
  localparam int SR_W = WIDTH;
`else
  localparam int SR_W = WIDTH - 1;
`endif

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [SR_W-1:0] sr_q;
  logic            frame_err_q;

  logic [SR_W-1:0]  sr_d;
  logic             last_data;
  logic             complete;
  logic [WIDTH-1:0] word;
  logic             word_par;

  // Truncating cast keeps the newest SR_W bits after shifting s_in in.
  assign sr_d      = SR_W'({sr_q, s_in});
  assign last_data = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
`ifdef DESER_PARITY_EN
    complete = s_valid && !s_start && (state_q == S_PARITY);
    word     = sr_q;
    word_par = even_par(64'({sr_q, s_in}));
`else
    complete = s_valid && !s_start && (state_q == S_SHIFT) && last_data;
    word     = {sr_q, s_in};
    word_par = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      sr_q        <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      if (s_valid) begin
        case (state_q)
          S_IDLE: begin
            // Bits without a start marker are noise between frames.
            if (s_start) begin
              sr_q    <= sr_d;
              cnt_q   <= CW'(1);
              state_q <= S_SHIFT;
            end
          end
          S_SHIFT: begin
            sr_q <= sr_d;
            if (s_start) begin
              frame_err_q <= 1'b1;
              cnt_q       <= CW'(1);
            end else if (last_data) begin
              cnt_q <= '0;
`ifdef DESER_PARITY_EN
              state_q <= S_PARITY;
`else
              state_q <= S_IDLE;
`endif
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          S_PARITY: begin
            if (s_start) begin
              frame_err_q <= 1'b1;
              sr_q        <= sr_d;
              cnt_q       <= CW'(1);
              state_q     <= S_SHIFT;
            end else begin
              // Parity bit is consumed by the output register, not shifted.
              state_q <= S_IDLE;
            end
          end
          default: begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  deser_out_reg #(
    .WIDTH (WIDTH)
  ) u_out (
    .clk       (clk),
    .rst       (rst),
    .load_i    (complete),
    .word_i    (word),
    .par_i     (word_par),
    .ready_i   (p_ready),
    .data_o    (p_out),
    .valid_o   (p_valid),
    .par_err_o (par_err),
    .overrun_o (overrun)
  );

  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
module tb_sipo_deserializer;

  localparam int WIDTH = 4;
`ifdef DESER_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             s_in, s_valid, s_start, p_ready;
  logic [WIDTH-1:0] p_out;
  logic             p_valid, overrun, frame_err, par_err;

  sipo_deserializer #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_in      (s_in),
    .s_valid   (s_valid),
    .s_start   (s_start),
    .p_out     (p_out),
    .p_valid   (p_valid),
    .p_ready   (p_ready),
    .overrun   (overrun),
    .frame_err (frame_err),
    .par_err   (par_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: bits of the word in flight, plus the output slot.
  bit   mq[$];
  logic m_hv, m_ovr, m_fe, m_par;
  int   m_word;

  typedef struct { logic v; logic st; logic b; logic rdy; } cyc_t;
  cyc_t stim[$];

  task automatic model_reset();
    mq.delete();
    m_hv = 0; m_word = 0; m_par = 0; m_ovr = 0; m_fe = 0;
  endtask

  task automatic model_step(input logic v, input logic st, input logic b, input logic rdy);
    bit done = 0;
    int w = 0;
    bit px = 0;
    m_ovr = 0;
    m_fe  = 0;
    if (v) begin
      if (st) begin
        if (mq.size() > 0) m_fe = 1;
        mq.delete();
        mq.push_back(b);
      end else if (mq.size() > 0) begin
        mq.push_back(b);
      end
      if (mq.size() == WIDTH + PB) begin
        done = 1;
        for (int i = 0; i < WIDTH; i++) w = w * 2 + int'(mq[i]);
        foreach (mq[i]) px ^= mq[i];
        mq.delete();
      end
    end
    if (done && (!m_hv || rdy)) begin
      m_hv = 1; m_word = w; m_par = px & (PB == 1);
    end else if (done) begin
      m_ovr = 1;
    end else if (m_hv && rdy) begin
      m_hv = 0;
    end
  endtask

  function automatic logic [WIDTH+3:0] exp_vec();
    logic [31:0] wv;
    wv = m_word;
    return {m_hv, wv[WIDTH-1:0], m_ovr, m_fe, m_par};
  endfunction

  function automatic logic [WIDTH+3:0] obs_vec();
    return {p_valid, p_out, overrun, frame_err, par_err};
  endfunction

  // Drive one cycle; inputs change 1 time unit after the active edge.
  task automatic tick(input logic v, input logic st, input logic b, input logic rdy);
    s_valid = v; s_start = st; s_in = b; p_ready = rdy;
    model_step(v, st, b, rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic add_cyc(input logic v, input logic st, input logic b, input logic rdy);
    cyc_t c;
    c.v = v; c.st = st; c.b = b; c.rdy = rdy;
    stim.push_back(c);
  endtask

  // Word MSB first with 'gap' idle cycles between bits; parity bit appended
  // (even parity, i.e. correct) when parity is compiled in.
  task automatic add_word(input logic [WIDTH-1:0] w, input int gap, input logic rdy);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (i < WIDTH - 1) for (int g = 0; g < gap; g++) add_cyc(0, 0, 0, rdy);
      add_cyc(1, (i == WIDTH - 1), w[i], rdy);
    end
    if (PB == 1) begin
      for (int g = 0; g < gap; g++) add_cyc(0, 0, 0, rdy);
      add_cyc(1, 0, ^w, rdy);
    end
  endtask

  task automatic test_reset();
    cyc_t c;
    rst = 1; s_in = 0; s_valid = 0; s_start = 0; p_ready = 0;
    model_reset();
    #2;
    total++;
    if (obs_vec() !== '0) begin
      bad++; $display("FAIL reset_initial got=%b want=%b", obs_vec(), {(WIDTH+4){1'b0}});
    end
    @(posedge clk); #1; rst = 0;
    // Fill the output slot, then start a second word and reset mid-word.
    add_word(4'b1100, 0, 0);
    add_cyc(1, 1, 1, 0);
    add_cyc(1, 0, 0, 0);
    while (stim.size() > 0) begin
      c = stim.pop_front();
      tick(c.v, c.st, c.b, c.rdy);
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL reset_fill got=%b want=%b", obs_vec(), exp_vec());
      end
    end
    #2; rst = 1; #1;
    model_reset();
    total++;
    if (obs_vec() !== '0) begin
      bad++; $display("FAIL reset_async got=%b want=%b", obs_vec(), {(WIDTH+4){1'b0}});
    end
    @(posedge clk); #1; rst = 0;
    add_word(4'b1011, 0, 0);
    while (stim.size() > 0) begin
      c = stim.pop_front();
      tick(c.v, c.st, c.b, c.rdy);
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL reset_after got=%b want=%b", obs_vec(), exp_vec());
      end
    end
    total++;
    if (p_valid !== 1'b1 || p_out !== 4'b1011) begin
      bad++; $display("FAIL reset_word got=%b/%b want=1/1011", p_valid, p_out);
    end
    tick(0, 0, 0, 1);
    total++;
    if (p_valid !== 1'b0) begin
      bad++; $display("FAIL reset_drain got=%b want=0", p_valid);
    end
  endtask

  task automatic test_single(input int gap, input string nm);
    cyc_t c;
    add_word(4'b1011, gap, 1);
    while (stim.size() > 0) begin
      c = stim.pop_front();
      tick(c.v, c.st, c.b, c.rdy);
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL %s got=%b want=%b", nm, obs_vec(), exp_vec());
      end
    end
    total++;
    if (p_valid !== 1'b1 || p_out !== 4'b1011 || frame_err !== 1'b0 || overrun !== 1'b0) begin
      bad++; $display("FAIL %s_word got=%b/%b want=1/1011", nm, p_valid, p_out);
    end
    tick(0, 0, 0, 1);
    total++;
    if (p_valid !== 1'b0) begin
      bad++; $display("FAIL %s_onecycle p_valid got=%b want=0", nm, p_valid);
    end
  endtask

  task automatic test_overrun();
    cyc_t c;
    add_word(4'b1011, 0, 0);
    add_word(4'b0110, 1, 0);
    while (stim.size() > 0) begin
      c = stim.pop_front();
      tick(c.v, c.st, c.b, c.rdy);
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL overrun got=%b want=%b", obs_vec(), exp_vec());
      end
    end
    total++;
    if (overrun !== 1'b1 || p_out !== 4'b1011 || p_valid !== 1'b1) begin
      bad++; $display("FAIL overrun_pulse got=%b/%b/%b want=1/1011/1", overrun, p_out, p_valid);
    end
    tick(0, 0, 0, 0);
    total++;
    if (overrun !== 1'b0 || p_valid !== 1'b1) begin
      bad++; $display("FAIL overrun_hold got=%b/%b want=0/1", overrun, p_valid);
    end
    tick(0, 0, 0, 1);
    total++;
    if (p_valid !== 1'b0) begin
      bad++; $display("FAIL overrun_drain got=%b want=0", p_valid);
    end
  endtask

  task automatic test_frame();
    cyc_t c;
    add_cyc(1, 1, 1, 1);
    add_cyc(1, 0, 1, 1);
    add_word(4'b0110, 0, 1);
    while (stim.size() > 0) begin
      c = stim.pop_front();
      tick(c.v, c.st, c.b, c.rdy);
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL frame got=%b want=%b", obs_vec(), exp_vec());
      end
      if (stim.size() == WIDTH - 1 + PB) begin
        total++;
        if (frame_err !== 1'b1) begin
          bad++; $display("FAIL frame_pulse got=%b want=1", frame_err);
        end
      end
    end
    total++;
    if (p_out !== 4'b0110 || p_valid !== 1'b1) begin
      bad++; $display("FAIL frame_word got=%b/%b want=0110/1", p_out, p_valid);
    end
    tick(0, 0, 0, 1);
  endtask

  task automatic test_back_to_back();
    cyc_t c;
    int words = 0;
    for (int k = 0; k < 6; k++) add_word(WIDTH'($urandom), 0, 1);
    while (stim.size() > 0) begin
      c = stim.pop_front();
      tick(c.v, c.st, c.b, c.rdy);
      if (p_valid === 1'b1) words++;
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL b2b got=%b want=%b", obs_vec(), exp_vec());
      end
    end
    total++;
    if (words != 6) begin
      bad++; $display("FAIL b2b_rate words got=%0d want=6", words);
    end
    tick(0, 0, 0, 1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      tick($urandom_range(0, 9) < 7, $urandom_range(0, WIDTH + 2) == 0,
           1'($urandom), $urandom_range(0, 3) != 0);
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL random cyc=%0d got=%b want=%b", n, obs_vec(), exp_vec());
      end
    end
    tick(0, 0, 0, 1);
  endtask

`ifdef DESER_PARITY_EN
  task automatic test_parity();
    cyc_t c;
    logic [4:0] pats [2];
    logic       want [2];
    pats[0] = 5'b10111; want[0] = 1'b0;
    pats[1] = 5'b10110; want[1] = 1'b1;
    for (int p = 0; p < 2; p++) begin
      for (int i = 4; i >= 0; i--) add_cyc(1, (i == 4), pats[p][i], 1);
      while (stim.size() > 0) begin
        c = stim.pop_front();
        tick(c.v, c.st, c.b, c.rdy);
        total++;
        if (obs_vec() !== exp_vec()) begin
          bad++; $display("FAIL parity got=%b want=%b", obs_vec(), exp_vec());
        end
      end
      total++;
      if (p_out !== 4'b1011 || par_err !== want[p]) begin
        bad++; $display("FAIL parity_word got=%b/%b want=1011/%b", p_out, par_err, want[p]);
      end
    end
    tick(0, 0, 0, 1);
  endtask
`endif

  initial begin
    test_reset();
    test_single(0, "single");
    test_single(3, "gaps");
    test_overrun();
    test_frame();
    test_back_to_back();
`ifdef DESER_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
